// File: rtl/decomp_mod_fold.sv
// Modular fold stage behind the single-LUT decomposition: adds the LUT partial residue and the
// truncated low bits, reduces modulo MODULUS, and buffers results with credit-based flow control.
module decomp_mod_fold #(
    parameter int DATA_WIDTH  = 18,
    parameter int TRUNC_WIDTH = 16,
    parameter int MODULUS     = 262139,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  lut_in,
    input  logic [TRUNC_WIDTH-1:0] trunc_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   err_ovf,
    output logic                   err_range
);

    localparam int SW = ((DATA_WIDTH > TRUNC_WIDTH) ? DATA_WIDTH : TRUNC_WIDTH) + 1;
    localparam int RW = SW + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [RW-1:0]         MOD1     = RW'(MODULUS);
    localparam logic [RW-1:0]         MOD2     = RW'(2 * MODULUS);
    localparam logic [DATA_WIDTH-1:0] MOD_D    = DATA_WIDTH'(MODULUS);
    localparam logic [PW-1:0]         PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW:0]           CREDITS  = (CW + 1)'(DEPTH);

    // Two conditional subtractions suffice because the sum is always below 3*MODULUS.
    function automatic logic [DATA_WIDTH-1:0] fold(input logic [SW-1:0] s);
        logic [RW-1:0] r;
        r = {1'b0, s};
        if (r >= MOD2) r = r - MOD2;
        else           r = r;
        if (r >= MOD1) r = r - MOD1;
        else           r = r;
        return r[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? {PW{1'b0}} : p + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    logic                  v1_r, v2_r;
    logic [SW-1:0]         s1_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  err_ovf_r, err_range_r;
    logic [CW:0]           credit_s;
    logic                  in_ready_s, accept_s, push_s, pop_s;

    // Credits count FIFO occupancy plus tagged words still in the pipeline; a pop frees one only next cycle.
    always_comb begin
        credit_s   = {1'b0, count_r} + {{CW{1'b0}}, v1_r} + {{CW{1'b0}}, v2_r};
        in_ready_s = (credit_s < CREDITS);
        accept_s   = in_valid & in_ready_s;
        push_s     = v2_r;
        pop_s      = (count_r != {CW{1'b0}}) & out_ready;
    end

    // Valid tags, sum register and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            s1_r        <= {SW{1'b0}};
            err_ovf_r   <= 1'b0;
            err_range_r <= 1'b0;
        end else begin
            v1_r <= accept_s;
            v2_r <= v1_r;
            if (v1_r) s1_r <= SW'(lut_in) + SW'(trunc_in);
            else      s1_r <= s1_r;
            if (in_valid && !in_ready_s) err_ovf_r <= 1'b1;
            else                         err_ovf_r <= err_ovf_r;
            if (v1_r && (lut_in >= MOD_D)) err_range_r <= 1'b1;
            else                           err_range_r <= err_range_r;
        end
    end

    // Circular output buffer; the credit rule guarantees a push never meets a full buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= fold(s1_r);
                wr_ptr_r        <= ptr_next(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ptr_next(rd_ptr_r);
            else       rd_ptr_r <= rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (count_r != {CW{1'b0}});
    assign out_data  = out_valid ? mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign err_ovf   = err_ovf_r;
    assign err_range = err_range_r;

endmodule

// File: tb/tb_decomp_mod_fold.sv
// Randomized self-checking bench for decomp_mod_fold, modelling the upstream stage's one-cycle
// data delay and predicting outputs from a queue of accepted words and their arrival cycles.
module tb_decomp_mod_fold;

    localparam int M     = 262139;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] lut_in = 18'd0;
    logic [15:0] trunc_in = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] out_data;
    logic        err_ovf, err_range;

    decomp_mod_fold #(.DATA_WIDTH(18), .TRUNC_WIDTH(16), .MODULUS(M), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .lut_in(lut_in), .trunc_in(trunc_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .err_ovf(err_ovf), .err_range(err_range)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int rc; } ent_t;
    ent_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          pend = 1'b0;
    logic [17:0] pend_lut = 18'd0, cur_l = 18'd0;
    logic [15:0] pend_trunc = 16'd0, cur_t = 16'd0;
    bit          exp_ready, exp_valid, exp_ovf = 1'b0, exp_range = 1'b0;
    int          exp_data;

    // Present one cycle's inputs and compute what the outputs must show this cycle.
    task automatic setup(input bit v, input logic [17:0] l, input logic [15:0] t);
        exp_ready = (q.size() < DEPTH);
        exp_valid = (q.size() > 0) && (q[0].rc <= cyc);
        exp_data  = exp_valid ? q[0].val : 0;
        in_valid  = v;
        cur_l     = l;
        cur_t     = t;
        lut_in    = pend ? pend_lut : 18'($urandom);
        trunc_in  = pend ? pend_trunc : 16'($urandom);
        #1;
    endtask

    task automatic advance();
        bit acc;
        acc = in_valid && exp_ready;
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && !exp_ready) exp_ovf = 1'b1;
        if (pend && (int'(pend_lut) >= M)) exp_range = 1'b1;
        if (acc) q.push_back('{val: (int'(cur_l) + int'(cur_t)) % M, rc: cyc + 3});
        pend       = acc;
        pend_lut   = cur_l;
        pend_trunc = cur_t;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            setup(1'b0, 18'd0, 16'd0);
            advance();
        end
    endtask

    task automatic model_clear();
        q.delete();
        pend = 1'b0;
        exp_ovf = 1'b0;
        exp_range = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 18'd0 || in_ready !== 1'b1 || err_ovf !== 1'b0 || err_range !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%0d ready=%b ovf=%b rng=%b, expected 0 0 1 0 0",
                     out_valid, out_data, in_ready, err_ovf, err_range);
        end
    endtask

    task automatic test_boundaries();
        logic [17:0] ls [5] = '{18'd262138, 18'd200000, 18'd0, 18'd262138, 18'd1};
        logic [15:0] ts [5] = '{16'd65535, 16'd62139, 16'd5, 16'd0, 16'd65535};
        int seen;
        out_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                setup(c == 0, ls[w], ts[w]);
                checks++;
                if (out_valid !== exp_valid || (exp_valid && out_data !== 18'(exp_data))) begin
                    errors++;
                    $display("FAIL boundary w%0d c%0d: valid=%b data=%0d, expected %b %0d",
                             w, c, out_valid, out_data, exp_valid, exp_data);
                end
                if (out_valid) seen++;
                advance();
            end
            checks++;
            if (seen !== 1 || err_ovf !== 1'b0 || err_range !== 1'b0) begin
                errors++;
                $display("FAIL boundary_once w%0d: outputs=%0d ovf=%b rng=%b, expected 1 0 0", w, seen, err_ovf, err_range);
            end
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            setup(c < 10, 18'd0, 16'(c));
            checks++;
            if (in_ready !== 1'b1 || out_valid !== exp_valid || (exp_valid && out_data !== 18'(exp_data))) begin
                errors++;
                $display("FAIL stream c%0d: ready=%b valid=%b data=%0d, expected 1 %b %0d",
                         c, in_ready, out_valid, out_data, exp_valid, exp_data);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            out_ready = 1'($urandom);
            setup(($urandom_range(3, 0) != 0) && (q.size() < DEPTH),
                  18'($urandom_range(M - 1, 0)), 16'($urandom));
            checks++;
            if (in_ready !== exp_ready || out_valid !== exp_valid || (exp_valid && out_data !== 18'(exp_data))
                || err_ovf !== exp_ovf || err_range !== exp_range) begin
                errors++;
                $display("FAIL random c%0d: ready=%b valid=%b data=%0d ovf=%b rng=%b, expected %b %b %0d %b %b",
                         c, in_ready, out_valid, out_data, err_ovf, err_range,
                         exp_ready, exp_valid, exp_data, exp_ovf, exp_range);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int popped;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            setup(1'b1, 18'(1000 * c), 16'(c));
            checks++;
            if (in_ready !== exp_ready || out_valid !== exp_valid) begin
                errors++;
                $display("FAIL backpressure c%0d: ready=%b valid=%b, expected %b %b", c, in_ready, out_valid, exp_ready, exp_valid);
            end
            advance();
        end
        checks++;
        if (err_ovf !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL overflow: ovf=%b ready=%b, expected 1 0", err_ovf, in_ready);
        end
        out_ready = 1'b1;
        popped = 0;
        for (int c = 0; c < 10; c++) begin
            setup(1'b0, 18'd0, 16'd0);
            checks++;
            if (out_valid !== exp_valid || (exp_valid && out_data !== 18'(exp_data))) begin
                errors++;
                $display("FAIL drain c%0d: valid=%b data=%0d, expected %b %0d", c, out_valid, out_data, exp_valid, exp_data);
            end
            if (out_valid) popped++;
            advance();
        end
        checks++;
        if (popped !== 4) begin
            errors++;
            $display("FAIL drain_count: got %0d words, expected 4", popped);
        end
    endtask

    task automatic test_range();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            setup(c == 0, 18'd262140, 16'd0);
            checks++;
            if (err_range !== exp_range || out_valid !== exp_valid || (exp_valid && out_data !== 18'(exp_data))) begin
                errors++;
                $display("FAIL range c%0d: rng=%b valid=%b data=%0d, expected %b %b %0d",
                         c, err_range, out_valid, out_data, exp_range, exp_valid, exp_data);
            end
            advance();
        end
        checks++;
        if (err_range !== 1'b1) begin
            errors++;
            $display("FAIL range_sticky: rng=%b, expected 1", err_range);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            setup(1'b1, 18'(c + 7), 16'd3);
            advance();
        end
        setup(1'b0, 18'd0, 16'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #4;
        reset_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 18'd0 || in_ready !== 1'b1 || err_ovf !== 1'b0 || err_range !== 1'b0) begin
            errors++;
            $display("FAIL midreset: valid=%b data=%0d ready=%b ovf=%b rng=%b, expected 0 0 1 0 0",
                     out_valid, out_data, in_ready, err_ovf, err_range);
        end
        model_clear();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            setup(1'b0, 18'd0, 16'd0);
            checks++;
            if (out_valid !== 1'b0 || out_data !== 18'd0) begin
                errors++;
                $display("FAIL stale c%0d: valid=%b data=%0d, expected 0 0", c, out_valid, out_data);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_boundaries();
        idle(4);
        test_stream();
        idle(4);
        test_random();
        idle(6);
        test_backpressure();
        idle(4);
        test_range();
        idle(4);
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decomp_mod_fold.md
Name: decomp_mod_fold

Overview:
- Stage directly downstream of the single-stage, single-LUT decomposition circuit.
- Consumes that stage's registered LUT partial residue (lut_out) and its truncated low bits (trunc_out), adds them, and reduces the sum modulo MODULUS to a canonical residue.
- Supplies the valid-tag alignment and credit-based flow control that the decomposition stage lacks, and buffers results in an output FIFO with a ready/valid interface toward the next pipeline element.

Parameters:
- DATA_WIDTH, 18, width of lut_in and of the result.
- TRUNC_WIDTH, 16, width of trunc_in.
- MODULUS, 262139, reduction modulus. Constraints: MODULUS < 2^DATA_WIDTH and 2^TRUNC_WIDTH <= 2*MODULUS.
- DEPTH, 4, output FIFO entries. Minimum 3; DEPTH >= 4 is needed for one result per cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies the word presented to the decomposition stage's in_a this cycle.
- in_ready  out  1  upstream may assert in_valid only while in_ready=1.
- lut_in  in  DATA_WIDTH  decomposition stage lut_out, valid one cycle after its in_a was sampled.
- trunc_in  in  TRUNC_WIDTH  decomposition stage trunc_out, same timing as lut_in.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head; pop when out_valid & out_ready.
- out_data  out  DATA_WIDTH  reduced residue at the FIFO head.
- err_ovf  out  1  sticky: in_valid was asserted while in_ready=0.
- err_range  out  1  sticky: a tagged lut_in was >= MODULUS.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Tags v1 and v2 = 0; FIFO empty; out_valid=0; out_data=0; err_ovf=0; err_range=0.
  - in_ready=1 once reset is released.
  - Anything in flight is discarded. Unreset decomposition-stage registers are ignored because the tags are cleared.
- Timing, with in_valid high in cycle c (sampled at end of c, the same edge at which the decomposition stage latches in_a):
  - Cycle c+1: v1=1; lut_in and trunc_in carry the word's data.
  - End of c+1: s1 <= lut_in + trunc_in, width max(DATA_WIDTH,TRUNC_WIDTH)+1; v2 <= v1.
  - End of c+2: reduced value written to the FIFO if v2=1.
  - Cycle c+3 at the earliest: out_valid=1.
  - Fixed latency of 3 cycles to an empty FIFO.
- Reduction (combinational from s1):
  - r = s1; if r >= 2*MODULUS then r -= 2*MODULUS; then if r >= MODULUS then r -= MODULUS.
  - Result is truncated to DATA_WIDTH and is always < MODULUS when the parameter constraints hold.
- err_range:
  - Set when v1=1 and lut_in >= MODULUS.
  - The data is still processed and the reduction is still applied.
- Flow control:
  - inflight = v1 + v2 (0..2).
  - in_ready = (fifo_count + inflight) < DEPTH, registered-input combinational, with no pop lookahead.
  - A pop in the same cycle does not raise in_ready until the next cycle.
- Overflow:
  - If in_valid=1 while in_ready=0, the word is not tagged (v1 stays 0) and err_ovf is set.
  - The FIFO is never written when full; this is guaranteed by the credit rule.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count.
  - Simultaneous push and pop when full or when empty-with-push are both legal. The count is unchanged on simultaneous push+pop.
  - Strict in-order delivery.
  - out_data holds its value while out_valid=1 and out_ready=0.
- Error flags: err_ovf and err_range clear only on reset.

Test Plan:
- Basic reduction: single word with lut_in=262138, trunc_in=65535 -> s1=327673 -> out_data=65534 with out_valid in cycle c+3; err flags remain 0.
- Exact-modulus boundaries:
  - lut_in=200000, trunc_in=62139 -> out_data=0.
  - lut_in=0, trunc_in=5 -> out_data=5.
  - lut_in=262138, trunc_in=0 -> out_data=262138.
- Streaming: out_ready=1, in_valid held high for 10 cycles with trunc_in=k, lut_in=0 -> in_ready stays 1; out_data=0..9 on consecutive cycles c+3..c+12.
- Backpressure and overflow:
  - out_ready=0; four words accepted, then in_ready=0 on the cycle after the 4th sample.
  - A 5th in_valid sets err_ovf=1 and is never output.
  - Raising out_ready then drains exactly the 4 words in order.
- Range error: lut_in=262140 (>= MODULUS) with trunc_in=0 -> err_range=1 (sticky); out_data=1.
- Reset mid-flight: two words in flight plus 2 in the FIFO, pulse reset_n low for 1 cycle -> out_valid=0, out_data=0, flags 0 and in_ready=1 immediately after release; no stale outputs ever appear.
